// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame assembler.
// FRAME_CHECKSUM_EN adds the checksum state to the frame state enum.
package uart_frame_pkg;

    localparam logic [7:0]  SyncByteDefault = 8'hAA;
    localparam int unsigned ErrCountWidth   = 8;

`ifdef FRAME_CHECKSUM_EN
    typedef enum logic [1:0] {
        StIdle,
        StGetHi,
        StGetLo,
        StGetChk
    } frame_state_e;
`else
    typedef enum logic [1:0] {
        StIdle,
        StGetHi,
        StGetLo
    } frame_state_e;
`endif

endpackage

// File: rtl/frame_timeout_counter.sv
// Inter-byte timeout counter: saturates at TIMEOUT_CYCLES-1 and flags expiry there.
module frame_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned    CntWidth = $clog2(TIMEOUT_CYCLES);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(TIMEOUT_CYCLES - 1);

    logic [CntWidth-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != CntMax)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == CntMax);

endmodule

// File: rtl/uart_frame_assembler.sv
// Assembles sync/hi/lo[/chk] UART byte frames into 16-bit words with timeout and error tracking.
// Define FRAME_CHECKSUM_EN for 4-byte frames with an XOR checksum byte.
module uart_frame_assembler
    import uart_frame_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0]  SYNC_BYTE      = SyncByteDefault
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               Rx_DATA,
    input  logic                     Rx_VALID,
    input  logic                     Rx_FERROR,
    input  logic                     Rx_PERROR,
    output logic [15:0]              data_out,
    output logic                     data_valid,
    output logic                     frame_err,
    output logic [ErrCountWidth-1:0] err_count,
    output logic [3:0]               digit0,
    output logic [3:0]               digit1,
    output logic [3:0]               digit2,
    output logic [3:0]               digit3
);

    frame_state_e state_d, state_q;

    logic                     rx_valid_q;
    logic                     armed_d, armed_q;
    logic [7:0]               hi_d, hi_q;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]               lo_d, lo_q;
`endif
    logic [15:0]              data_d, data_q;
    logic                     data_valid_d, data_valid_q;
    logic                     frame_err_d, frame_err_q;
    logic [ErrCountWidth-1:0] err_count_d, err_count_q;

    logic        accept;
    logic        byte_err;
    logic        expired;
    logic        abort;
    logic        complete;
    logic [15:0] word;

    // A Rx_VALID still high out of reset must drop once before any edge counts.
    assign armed_d  = armed_q | ~Rx_VALID;
    assign accept   = Rx_VALID & ~rx_valid_q & armed_q;
    assign byte_err = Rx_FERROR | Rx_PERROR;

    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
`ifdef FRAME_CHECKSUM_EN
        lo_d         = lo_q;
`endif
        data_d       = data_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        err_count_d  = err_count_q;
        abort        = 1'b0;
        complete     = 1'b0;
        word         = data_q;

        case (state_q)
            StIdle: begin
                if (accept && (Rx_DATA == SYNC_BYTE)) begin
                    if (byte_err) begin
                        abort = 1'b1;
                    end else begin
                        state_d = StGetHi;
                    end
                end
            end
            StGetHi: begin
                if (accept) begin
                    if (byte_err) begin
                        abort = 1'b1;
                    end else begin
                        hi_d    = Rx_DATA;
                        state_d = StGetLo;
                    end
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
            StGetLo: begin
                if (accept) begin
                    if (byte_err) begin
                        abort = 1'b1;
                    end else begin
`ifdef FRAME_CHECKSUM_EN
                        lo_d    = Rx_DATA;
                        state_d = StGetChk;
`else
                        complete = 1'b1;
                        word     = {hi_q, Rx_DATA};
`endif
                    end
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
`ifdef FRAME_CHECKSUM_EN
            StGetChk: begin
                if (accept) begin
                    if (byte_err || (Rx_DATA != (hi_q ^ lo_q))) begin
                        abort = 1'b1;
                    end else begin
                        complete = 1'b1;
                        word     = {hi_q, lo_q};
                    end
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        if (abort) begin
            state_d     = StIdle;
            frame_err_d = 1'b1;
            if (err_count_q != '1) begin
                err_count_d = err_count_q + 1'b1;
            end
        end else if (complete) begin
            state_d      = StIdle;
            data_d       = word;
            data_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            rx_valid_q   <= 1'b0;
            armed_q      <= 1'b0;
            hi_q         <= 8'h00;
`ifdef FRAME_CHECKSUM_EN
            lo_q         <= 8'h00;
`endif
            data_q       <= 16'h0000;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            rx_valid_q   <= Rx_VALID;
            armed_q      <= armed_d;
            hi_q         <= hi_d;
`ifdef FRAME_CHECKSUM_EN
            lo_q         <= lo_d;
`endif
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            err_count_q  <= err_count_d;
        end
    end

    frame_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (accept || (state_q == StIdle) || (state_d == StIdle)),
        .enable (state_q != StIdle),
        .expired(expired)
    );

    assign data_out   = data_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign err_count  = err_count_q;
    assign digit0     = data_q[3:0];
    assign digit1     = data_q[7:4];
    assign digit2     = data_q[11:8];
    assign digit3     = data_q[15:12];

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Directed self-checking bench for uart_frame_assembler (TIMEOUT_CYCLES = 16).
module tb_uart_frame_assembler;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  Rx_DATA = 8'h00;
    logic        Rx_VALID = 1'b0;
    logic        Rx_FERROR = 1'b0;
    logic        Rx_PERROR = 1'b0;
    logic [15:0] data_out;
    logic        data_valid;
    logic        frame_err;
    logic [7:0]  err_count;
    logic [3:0]  digit0, digit1, digit2, digit3;

    int n_checks = 0;
    int n_errors = 0;
    int dv_cnt   = 0;
    int fe_cnt   = 0;
    int both_cnt = 0;
    int dv_snap, fe_snap;
    int exp_err  = 0;

    always #5 clock = ~clock;

    uart_frame_assembler #(
        .TIMEOUT_CYCLES(16),
        .SYNC_BYTE     (8'hAA)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .Rx_DATA   (Rx_DATA),
        .Rx_VALID  (Rx_VALID),
        .Rx_FERROR (Rx_FERROR),
        .Rx_PERROR (Rx_PERROR),
        .data_out  (data_out),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .err_count (err_count),
        .digit0    (digit0),
        .digit1    (digit1),
        .digit2    (digit2),
        .digit3    (digit3)
    );

    always @(negedge clock) begin
        if (data_valid) dv_cnt++;
        if (frame_err) fe_cnt++;
        if (data_valid && frame_err) both_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic fe, input logic pe, input int hold);
        Rx_DATA   = d;
        Rx_FERROR = fe;
        Rx_PERROR = pe;
        Rx_VALID  = 1'b1;
        repeat (hold) @(posedge clock);
        #1;
        Rx_VALID  = 1'b0;
        Rx_FERROR = 1'b0;
        Rx_PERROR = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic send4(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
        send_byte(b0, 1'b0, 1'b0, 1);
        send_byte(b1, 1'b0, 1'b0, 1);
        send_byte(b2, 1'b0, 1'b0, 1);
        send_byte(b3, 1'b0, 1'b0, 1);
    endtask

    task automatic snap();
        dv_snap = dv_cnt;
        fe_snap = fe_cnt;
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_data_out", 32'(data_out), 32'h0);
        check_eq("rst_data_valid", 32'(data_valid), 32'h0);
        check_eq("rst_frame_err", 32'(frame_err), 32'h0);
        check_eq("rst_err_count", 32'(err_count), 32'h0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Basic frame
        snap();
        send4(8'hAA, 8'h12, 8'h34, 8'h26);
        check_eq("f1234_data", 32'(data_out), 32'h1234);
        check_eq("f1234_dv", 32'(dv_cnt - dv_snap), 32'd1);
        check_eq("f1234_fe", 32'(fe_cnt - fe_snap), 32'd0);
        check_eq("f1234_digits", 32'({digit3, digit2, digit1, digit0}), 32'h1234);

        // Framing error on lo byte
        snap();
        send_byte(8'hAA, 1'b0, 1'b0, 1);
        send_byte(8'h12, 1'b0, 1'b0, 1);
        send_byte(8'h34, 1'b1, 1'b0, 1);
        exp_err++;
        check_eq("ferr_lo_fe", 32'(fe_cnt - fe_snap), 32'd1);
        check_eq("ferr_lo_cnt", 32'(err_count), 32'(exp_err));
        check_eq("ferr_lo_data", 32'(data_out), 32'h1234);

`ifdef FRAME_CHECKSUM_EN
        snap();
        send4(8'hAA, 8'h12, 8'h34, 8'h00);
        exp_err++;
        check_eq("badchk_fe", 32'(fe_cnt - fe_snap), 32'd1);
        check_eq("badchk_dv", 32'(dv_cnt - dv_snap), 32'd0);
        check_eq("badchk_cnt", 32'(err_count), 32'(exp_err));
        check_eq("badchk_data", 32'(data_out), 32'h1234);
`endif

        // Leading junk ignored; sync value inside frame is data
        snap();
        send_byte(8'h55, 1'b0, 1'b0, 1);
        send4(8'hAA, 8'hAA, 8'h0F, 8'hA5);
        check_eq("syncdata_data", 32'(data_out), 32'hAA0F);
        check_eq("syncdata_fe", 32'(fe_cnt - fe_snap), 32'd0);
        check_eq("syncdata_dv", 32'(dv_cnt - dv_snap), 32'd1);

        // Timeout mid-frame, then recovery
        snap();
        send_byte(8'hAA, 1'b0, 1'b0, 1);
        send_byte(8'h12, 1'b0, 1'b0, 1);
        repeat (20) @(posedge clock);
        #1;
        exp_err++;
        check_eq("tmo_fe", 32'(fe_cnt - fe_snap), 32'd1);
        check_eq("tmo_cnt", 32'(err_count), 32'(exp_err));
        send4(8'hAA, 8'h56, 8'h78, 8'h2E);
        check_eq("tmo_recover_data", 32'(data_out), 32'h5678);

        // Byte arriving exactly on the timeout cycle wins
        snap();
        send_byte(8'hAA, 1'b0, 1'b0, 1);
        send_byte(8'h0C, 1'b0, 1'b0, 1);
        repeat (14) @(posedge clock);
        #1;
        send_byte(8'h3D, 1'b0, 1'b0, 1);
        send_byte(8'h31, 1'b0, 1'b0, 1);
        check_eq("tmo_edge_fe", 32'(fe_cnt - fe_snap), 32'd0);
        check_eq("tmo_edge_data", 32'(data_out), 32'h0C3D);

        // One cycle later the frame has already aborted
        snap();
        send_byte(8'hAA, 1'b0, 1'b0, 1);
        send_byte(8'h0C, 1'b0, 1'b0, 1);
        repeat (15) @(posedge clock);
        #1;
        send_byte(8'h3E, 1'b0, 1'b0, 1);
        send_byte(8'h32, 1'b0, 1'b0, 1);
        exp_err++;
        check_eq("tmo_late_fe", 32'(fe_cnt - fe_snap), 32'd1);
        check_eq("tmo_late_data", 32'(data_out), 32'h0C3D);

        // Parity error on hi byte
        snap();
        send_byte(8'hAA, 1'b0, 1'b0, 1);
        send_byte(8'h12, 1'b0, 1'b1, 1);
        exp_err++;
        check_eq("perr_hi_fe", 32'(fe_cnt - fe_snap), 32'd1);
        check_eq("perr_hi_cnt", 32'(err_count), 32'(exp_err));

        // Rx_VALID held high for several cycles counts once
        snap();
        send_byte(8'hAA, 1'b0, 1'b0, 4);
        send_byte(8'h9A, 1'b0, 1'b0, 3);
        send_byte(8'hBC, 1'b0, 1'b0, 1);
        send_byte(8'h26, 1'b0, 1'b0, 1);
        check_eq("hold_data", 32'(data_out), 32'h9ABC);
        check_eq("hold_dv", 32'(dv_cnt - dv_snap), 32'd1);

        // Reset mid-frame with Rx_VALID held high across release
        snap();
        send_byte(8'hAA, 1'b0, 1'b0, 1);
        send_byte(8'h12, 1'b0, 1'b0, 1);
        Rx_DATA  = 8'hAA;
        Rx_VALID = 1'b1;
        reset    = 1'b0;
        #2;
        check_eq("midrst_data", 32'(data_out), 32'h0);
        check_eq("midrst_dv", 32'(data_valid), 32'h0);
        check_eq("midrst_fe", 32'(frame_err), 32'h0);
        check_eq("midrst_cnt", 32'(err_count), 32'h0);
        check_eq("midrst_digit3", 32'(digit3), 32'h0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        Rx_VALID = 1'b0;
        @(posedge clock);
        #1;
        send_byte(8'h12, 1'b0, 1'b0, 1);
        send_byte(8'h34, 1'b0, 1'b0, 1);
        send_byte(8'h26, 1'b0, 1'b0, 1);
        check_eq("midrst_no_fe", 32'(fe_cnt - fe_snap), 32'd0);
        check_eq("held_valid_ignored_data", 32'(data_out), 32'h0);
        check_eq("held_valid_ignored_dv", 32'(dv_cnt - dv_snap), 32'd0);

        // Saturation of err_count
        snap();
        for (int i = 0; i < 300; i++) begin
            send_byte(8'hAA, 1'b1, 1'b0, 1);
        end
        check_eq("sat_fe_pulses", 32'(fe_cnt - fe_snap), 32'd300);
        check_eq("sat_err_count", 32'(err_count), 32'd255);
        check_eq("sat_data", 32'(data_out), 32'h0);

        check_eq("dv_fe_overlap", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_frame_assembler.md
UART_FRAME_ASSEMBLER -- requirements
Module: uart_frame_assembler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, inter-byte timeout in clock cycles (must be >= 2).
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hAA, frame start marker.
REQ-003 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port Rx_DATA  input  8  received byte from the UART receiver.
REQ-006 SHALL have port Rx_VALID  input  1  byte-available strobe; may be held high for several cycles.
REQ-007 SHALL have port Rx_FERROR  input  1  framing error of the current byte.
REQ-008 SHALL have port Rx_PERROR  input  1  parity error of the current byte.
REQ-009 SHALL have port data_out  output  16  last accepted word, held until the next accepted frame.
REQ-010 SHALL have port data_valid  output  1  one-cycle pulse when data_out updates.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse on any aborted frame.
REQ-012 SHALL have port err_count  output  8  saturating count of aborted frames.
REQ-013 SHALL have ports digit0..digit3  output  4 each  nibbles of data_out; digit0 = bits 3:0 through digit3 = bits 15:12.

Function
REQ-014 SHALL accept a byte only on a Rx_VALID rising edge: registered previous value 0, current value 1.
REQ-015 SHALL implement states IDLE, GET_HI, GET_LO and GET_CHK.
REQ-016 In IDLE, SHALL move to GET_HI on an accepted byte equal to SYNC_BYTE, and SHALL silently ignore all other bytes.
REQ-017 SHALL store the GET_HI byte as bits 15:8 and move to GET_LO.
REQ-018 SHALL store the GET_LO byte as bits 7:0 and move to GET_CHK (checksum enabled) or complete the frame (checksum disabled).
REQ-019 In GET_CHK, SHALL complete the frame if the byte equals hi XOR lo, and SHALL otherwise abort.
REQ-020 On completion, SHALL update data_out and pulse data_valid in the cycle after the last byte edge (latency 1), then return to IDLE.
REQ-021 SHALL treat SYNC_BYTE arriving in GET_HI, GET_LO or GET_CHK as ordinary data, with no resync.
REQ-022 SHALL abort when an accepted byte, in any non-IDLE state or as the sync byte, has Rx_FERROR or Rx_PERROR set.
REQ-023 SHALL keep an inter-byte counter that clears on every accepted byte and on entering IDLE, and counts only outside IDLE.
REQ-024 SHALL abort when the inter-byte counter reaches TIMEOUT_CYCLES-1 while no byte is accepted in that cycle.
REQ-025 If a byte edge and a timeout coincide, SHALL give priority to the byte.
REQ-026 On abort, SHALL pulse frame_err for one cycle, increment err_count saturating at 255, return to IDLE, and leave data_out unchanged.
REQ-027 SHALL never assert data_valid and frame_err in the same cycle.
REQ-028 SHALL drive digit0..digit3 combinationally from the data_out register.

Reset
REQ-029 On reset low, SHALL immediately force state IDLE, data_out 0, data_valid 0, frame_err 0, err_count 0, counter 0 and edge register 0.
REQ-030 Reset mid-frame SHALL discard partial bytes without pulsing frame_err.
REQ-031 After reset release, SHALL treat a Rx_VALID already high as having no edge until it goes low and then high again.

Configuration
REQ-032 With macro FRAME_CHECKSUM_EN defined, SHALL use 4-byte frames (sync, hi, lo, chk) including GET_CHK.
REQ-033 Without FRAME_CHECKSUM_EN, SHALL use 3-byte frames, omit GET_CHK and its compare logic, and leave every other behaviour unchanged.

Structure
REQ-034 SHALL place the state enum type, the default SYNC_BYTE value and the err_count width in shared package uart_frame_pkg.
REQ-035 SHALL implement the inter-byte timeout in one sub-module, frame_timeout_counter, with inputs clear and enable and output expired.

Verification
REQ-036 Checksum on: bytes AA 12 34 26 -> data_out 16'h1234, one data_valid pulse, digit3..digit0 = 1,2,3,4.
REQ-037 Checksum on: bytes AA 12 34 00 -> one frame_err pulse, err_count 1, data_out keeps its prior value.
REQ-038 Bytes 55 AA AA 0F A5 -> leading 55 ignored, data_out 16'hAA0F, no frame_err.
REQ-039 TIMEOUT_CYCLES=16, bytes AA 12 then 20 idle cycles -> frame_err pulse; next AA 56 78 2E -> data_out 16'h5678.
REQ-040 Rx_PERROR=1 on the hi byte of AA 12 -> frame_err pulse; reset asserted mid-frame -> all outputs 0 with no frame_err; 300 bad frames -> err_count 255.
